traffic_ctrl: RTL and testbench
===============================

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 Parameter GREEN_T, default 25, green-phase duration in clk_divide cycles; legal range 1..29.
REQ-002 Parameter YELLOW_T, default 5, yellow-phase duration in clk_divide cycles; legal range 1..29; GREEN_T+YELLOW_T SHALL be <=30.
REQ-003 clk_divide  input  1  divided phase clock; one cycle = one displayed second.
REQ-004 rst_n  input  1  reset; asynchronous, active-high.
REQ-005 run  input  1  1 = timers advance; 0 = freeze state and counts.
REQ-006 night  input  1  1 = night flash mode request.
REQ-007 data  output  8  NS countdown, binary 0..30, to display stage.
REQ-008 data2  output  8  EW countdown, binary 0..30, to display stage.
REQ-009 enable  output  1  display enable; 0 blanks display.
REQ-010 light_ns  output  3  NS lamps {red,yellow,green}, active-high.
REQ-011 light_ew  output  3  EW lamps {red,yellow,green}, active-high.

Function
REQ-012 The FSM SHALL have states NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, NIGHT; all outputs are registered on posedge clk_divide.
REQ-013 The phase counter cnt SHALL load GREEN_T on entry to a GREEN state and YELLOW_T on entry to a YELLOW state, then decrement by 1 per cycle while run=1.
REQ-014 When cnt==1 and run=1, the next cycle SHALL transition NS_GREEN->NS_YELLOW->EW_GREEN->EW_YELLOW->NS_GREEN with the new phase count loaded; cnt never reaches 0 in normal states.
REQ-015 Lamps: NS_GREEN ns=001, ew=100; NS_YELLOW ns=010, ew=100; EW_GREEN ns=100, ew=001; EW_YELLOW ns=100, ew=010; exactly one lamp per direction lit.
REQ-016 Countdown: green/yellow direction shows cnt; red direction shows cnt+YELLOW_T in the opposite GREEN state and cnt in the opposite YELLOW state.
REQ-017 enable SHALL be 1 in all four normal states.
REQ-018 run=0 SHALL hold state, cnt, lamps and countdowns unchanged indefinitely.
REQ-019 night=1 SHALL force NIGHT on the next edge from any state, overriding run and any pending phase transition.
REQ-020 In NIGHT: data=data2=0, enable=0, red and green off, both yellow lamps toggle together every cycle, first NIGHT cycle yellow on.
REQ-021 night falling SHALL cause NIGHT->NS_GREEN with cnt=GREEN_T on the next edge, regardless of run.
REQ-022 Simultaneous cnt==1 and night=1: NIGHT wins; no intermediate phase output.

Reset
REQ-023 rst_n=1 SHALL asynchronously force state NS_GREEN, cnt=GREEN_T, data=GREEN_T, data2=GREEN_T+YELLOW_T, enable=1, light_ns=001, light_ew=100, flash toggle=0.
REQ-024 Reset asserted mid-phase or in NIGHT SHALL take effect immediately without waiting for a clock edge; first post-reset edge with run=1 gives data=GREEN_T-1.

Structure
REQ-025 Package traffic_pkg SHALL hold the state enumeration, 3-bit lamp constants (LAMP_RED, LAMP_YELLOW, LAMP_GREEN, LAMP_OFF) and the 30-count display limit.
REQ-026 One sub-module phase_timer (8-bit loadable down-counter with load, hold, and terminal flag cnt==1) is natural; the FSM and output decode stay in traffic_ctrl.
REQ-027 Parameter violations SHALL be caught by an elaboration-time check.

Verification
REQ-028 Reset, run=1, 30 cycles -> data 25..1 then 5..1, data2 30..1, light_ns 001 for 25 cycles then 010; light_ew 100 throughout.
REQ-029 Full cycle, 60 edges from reset -> back in NS_GREEN, data=25, data2=30; EW_GREEN entered at edge 30 with data=30, data2=25.
REQ-030 run=0 at data=12 for 10 cycles -> data stays 12, lamps stay unchanged; run=1 -> next edge data=11.
REQ-031 night=1 at data=1 in NS_YELLOW -> next edge enable=0, data=data2=0, both yellow lamps 010, toggling 000/010 alternately; night=0 -> NS_GREEN, data=25, data2=30.
REQ-032 rst_n pulse between edges during EW_GREEN -> outputs immediately equal REQ-023 values.
REQ-033 GREEN_T=3, YELLOW_T=1 -> NS data 3,2,1,1; EW data2 4,3,2,1; period 8 cycles.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    EW_GREEN,
    EW_YELLOW,
    NIGHT
  } state_t;

  // Lamp vectors are {red, yellow, green}, active-high.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  localparam int unsigned MAX_COUNT = 30;

endpackage

// File: rtl/traffic_ctrl_if.sv
// Control inputs and display/lamp outputs of the traffic light controller.
interface traffic_ctrl_if;
  logic       run;
  logic       night;
  logic [7:0] data;
  logic [7:0] data2;
  logic       enable;
  logic [2:0] light_ns;
  logic [2:0] light_ew;

  modport master (
    output run, night,
    input  data, data2, enable, light_ns, light_ew
  );

  modport slave (
    input  run, night,
    output data, data2, enable, light_ns, light_ew
  );
endinterface

// File: rtl/traffic_ctrl_phase_timer.sv
// Loadable 8-bit down-counter; exposes its next value so callers can register
// decoded outputs in the same edge as the count update.
module phase_timer #(
  parameter logic [7:0] INIT = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       hold,
  output logic [7:0] count,
  output logic [7:0] count_next,
  output logic       last
);

  always_comb begin
    count_next = count;
    if (load)       count_next = load_val;
    else if (!hold) count_next = count - 8'd1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) count <= INIT;
    else       count <= count_next;
  end

  assign last = (count == 8'd1);

endmodule

// File: rtl/traffic_ctrl.sv
// Two-way traffic light FSM with countdown displays and night flash mode.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_T  = 25,
  parameter int unsigned YELLOW_T = 5
) (
  input logic           clk_divide,
  input logic           rst_n,
  traffic_ctrl_if.slave bus
);

  if (GREEN_T < 1 || GREEN_T > 29 || YELLOW_T < 1 || YELLOW_T > 29 ||
      GREEN_T + YELLOW_T > MAX_COUNT) begin : g_bad_params
    $error("traffic_ctrl: illegal GREEN_T/YELLOW_T");
  end

  localparam logic [7:0] G8 = 8'(GREEN_T);
  localparam logic [7:0] Y8 = 8'(YELLOW_T);

  state_t     state, state_next;
  logic       flash, flash_next;
  logic       load, hold, last;
  logic [7:0] load_val, cnt, cnt_next;
  logic [7:0] data_next, data2_next;
  logic       enable_next;
  logic [2:0] ns_next, ew_next;

  phase_timer #(.INIT(G8)) u_timer (
    .clk        (clk_divide),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (load_val),
    .hold       (hold),
    .count      (cnt),
    .count_next (cnt_next),
    .last       (last)
  );

  always_comb begin
    state_next = state;
    flash_next = 1'b0;
    load       = 1'b0;
    load_val   = G8;
    hold       = 1'b1;
    if (bus.night) begin
      state_next = NIGHT;
      flash_next = (state == NIGHT) ? ~flash : 1'b1;
    end else if (state == NIGHT) begin
      state_next = NS_GREEN;
      load       = 1'b1;
    end else if (bus.run) begin
      if (last) begin
        load = 1'b1;
        unique case (state)
          NS_GREEN:  begin state_next = NS_YELLOW; load_val = Y8; end
          NS_YELLOW: state_next = EW_GREEN;
          EW_GREEN:  begin state_next = EW_YELLOW; load_val = Y8; end
          default:   state_next = NS_GREEN;
        endcase
      end else begin
        hold = 1'b0;
      end
    end
  end

  // Outputs are decoded from next state/count so they register on the same edge.
  always_comb begin
    data_next   = cnt_next;
    data2_next  = cnt_next;
    enable_next = 1'b1;
    ns_next     = LAMP_RED;
    ew_next     = LAMP_RED;
    unique case (state_next)
      NS_GREEN:  begin ns_next = LAMP_GREEN;  data2_next = cnt_next + Y8; end
      NS_YELLOW: ns_next = LAMP_YELLOW;
      EW_GREEN:  begin ew_next = LAMP_GREEN;  data_next = cnt_next + Y8; end
      EW_YELLOW: ew_next = LAMP_YELLOW;
      default: begin
        data_next   = '0;
        data2_next  = '0;
        enable_next = 1'b0;
        ns_next     = flash_next ? LAMP_YELLOW : LAMP_OFF;
        ew_next     = flash_next ? LAMP_YELLOW : LAMP_OFF;
      end
    endcase
  end

  always_ff @(posedge clk_divide or posedge rst_n) begin
    if (rst_n) begin
      state        <= NS_GREEN;
      flash        <= 1'b0;
      bus.data     <= G8;
      bus.data2    <= G8 + Y8;
      bus.enable   <= 1'b1;
      bus.light_ns <= LAMP_GREEN;
      bus.light_ew <= LAMP_RED;
    end else begin
      state        <= state_next;
      flash        <= flash_next;
      bus.data     <= data_next;
      bus.data2    <= data2_next;
      bus.enable   <= enable_next;
      bus.light_ns <= ns_next;
      bus.light_ew <= ew_next;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench: two controller instances against a cycle-position model.
module tb_traffic_ctrl;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] data2;
    logic       enable;
    logic [2:0] ns;
    logic [2:0] ew;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  traffic_ctrl_if bus0 ();
  traffic_ctrl_if bus1 ();

  traffic_ctrl dut0 (.clk_divide(clk), .rst_n(rst_n), .bus(bus0));
  traffic_ctrl #(.GREEN_T(3), .YELLOW_T(1)) dut1 (.clk_divide(clk), .rst_n(rst_n), .bus(bus1));

  int unsigned g[2] = '{25, 3};
  int unsigned y[2] = '{5, 1};
  int unsigned t[2];          // seconds elapsed within the full 2*(G+Y) cycle
  bit          nt[2];
  bit          ph[2];
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  function automatic exp_t expect_of(int i);
    exp_t e;
    int unsigned gg = g[i];
    int unsigned yy = y[i];
    int unsigned p  = 2 * (gg + yy);
    if (nt[i]) begin
      e.data = 8'd0; e.data2 = 8'd0; e.enable = 1'b0;
      e.ns = ph[i] ? 3'b010 : 3'b000;
      e.ew = e.ns;
      return e;
    end
    e.enable = 1'b1;
    if (t[i] < gg) begin
      e.ns = 3'b001; e.ew = 3'b100;
      e.data = 8'(gg - t[i]); e.data2 = 8'(gg + yy - t[i]);
    end else if (t[i] < gg + yy) begin
      e.ns = 3'b010; e.ew = 3'b100;
      e.data = 8'(gg + yy - t[i]); e.data2 = e.data;
    end else if (t[i] < 2 * gg + yy) begin
      e.ns = 3'b100; e.ew = 3'b001;
      e.data = 8'(p - t[i]); e.data2 = 8'(2 * gg + yy - t[i]);
    end else begin
      e.ns = 3'b100; e.ew = 3'b010;
      e.data = 8'(p - t[i]); e.data2 = e.data;
    end
    return e;
  endfunction

  function automatic void model_reset(int i);
    t[i] = 0; nt[i] = 1'b0; ph[i] = 1'b0;
  endfunction

  function automatic void model_step(int i, bit r, bit n);
    if (n) begin
      ph[i] = nt[i] ? ~ph[i] : 1'b1;
      nt[i] = 1'b1;
    end else if (nt[i]) begin
      nt[i] = 1'b0;
      t[i]  = 0;
    end else if (r) begin
      t[i] = (t[i] + 1) % (2 * (g[i] + y[i]));
    end
  endfunction

  function automatic exp_t actual(int i);
    if (i == 0) return {bus0.data, bus0.data2, bus0.enable, bus0.light_ns, bus0.light_ew};
    return {bus1.data, bus1.data2, bus1.enable, bus1.light_ns, bus1.light_ew};
  endfunction

  task automatic compare(string name, exp_t a, exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got data=%0d data2=%0d en=%b ns=%b ew=%b, want data=%0d data2=%0d en=%b ns=%b ew=%b",
               name, $time, a.data, a.data2, a.enable, a.ns, a.ew,
               e.data, e.data2, e.enable, e.ns, e.ew);
    end
  endtask

  task automatic step(bit r, bit n, bit do_rst);
    @(negedge clk);
    if (do_rst) begin
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
        model_reset(i);
        compare(i == 0 ? "async_reset_dut0" : "async_reset_dut1", actual(i), expect_of(i));
      end
      rst_n = 1'b0;
      #1;
    end
    bus0.run = r; bus0.night = n;
    bus1.run = r; bus1.night = n;
    for (int i = 0; i < 2; i++) model_step(i, r, n);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) compare("cycle_dut0", actual(0), q0.pop_front());
    if (q1.size() > 0) compare("cycle_dut1", actual(1), q1.pop_front());
  end

  initial begin
    bit r, n, rs;
    bus0.run = 1'b0; bus0.night = 1'b0;
    bus1.run = 1'b0; bus1.night = 1'b0;
    n = 1'b0;

    step(1'b1, 1'b0, 1'b1);
    repeat (99) step(1'b1, 1'b0, 1'b0);     // full cycle and beyond, ends inside EW_GREEN
    step(1'b1, 1'b0, 1'b1);                 // reset between edges during EW_GREEN
    repeat (28) step(1'b1, 1'b0, 1'b0);     // NS_YELLOW showing 1 next
    repeat (4) step(1'b1, 1'b1, 1'b0);      // night overrides the pending transition
    step(1'b1, 1'b0, 1'b0);
    repeat (13) step(1'b1, 1'b0, 1'b0);     // NS data reaches 12
    repeat (10) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    repeat (400) begin
      r  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) n = ~n;
      rs = ($urandom_range(0, 79) == 0);
      step(r, n, rs);
    end
    repeat (2) step(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
